// File: rtl/alu_defs.sv
// Shared ALU opcode constants, sequencer state encoding and MULTU/DIVU
// selectors used by the iterative multiply/divide controller.
package alu_defs;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_SRL = 3'b011;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    localparam logic [4:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide: picks the ALU
// operands and forms the next {acc,wq} from the ALU result.
module muldiv_step
    import alu_defs::*;
(
    input  logic        is_div,
    input  logic [31:0] acc,
    input  logic [31:0] wq,
    input  logic [31:0] opnd,
    input  logic [31:0] alu_result,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] acc_next,
    output logic [31:0] wq_next
);

    logic [31:0] sh;
    logic        carry;
    logic        ge;

    // acc[31] acts as the 33rd bit of the shifted partial remainder, so a set
    // bit means the subtraction always fits and the 32-bit ALU result is exact.
    always_comb begin
        sh       = {acc[30:0], wq[31]};
        carry    = (alu_result < acc);
        ge       = acc[31] | (sh >= opnd);
        alu_op   = ALU_ADD;
        alu_a    = acc;
        alu_b    = wq[0] ? opnd : 32'd0;
        acc_next = {carry, alu_result[31:1]};
        wq_next  = {alu_result[0], wq[31:1]};
        if (is_div == OP_DIVU) begin
            alu_op   = ALU_SUB;
            alu_a    = sh;
            alu_b    = opnd;
            acc_next = ge ? alu_result : sh;
            wq_next  = {wq[30:0], ge};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULTU/DIVU controller that borrows the EX-stage ALU for 32 cycles
// and presents a 64-bit HI/LO result with a one-cycle done pulse.
module muldiv_sequencer
    import alu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_div,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        flush,
    output logic [2:0]  alu_op,
    output logic [4:0]  alu_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state, state_next;
    logic [31:0] acc, wq, opnd;
    logic [4:0]  cnt;
    logic        is_div;
    logic        load, step, last;
    logic [2:0]  step_op;
    logic [31:0] step_a, step_b, acc_next, wq_next;

    muldiv_step u_step (
        .is_div     (is_div),
        .acc        (acc),
        .wq         (wq),
        .opnd       (opnd),
        .alu_result (alu_result),
        .alu_op     (step_op),
        .alu_a      (step_a),
        .alu_b      (step_b),
        .acc_next   (acc_next),
        .wq_next    (wq_next)
    );

    // A flush only aborts RUN; in IDLE/DONE a concurrent start still wins.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_next = ST_DONE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign last = step && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The counter parks at 31 on the final step; only a reload returns it to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= 32'd0;
            wq     <= 32'd0;
            opnd   <= 32'd0;
            cnt    <= 5'd0;
            is_div <= OP_MULTU;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else if (load) begin
            acc    <= 32'd0;
            wq     <= opA;
            opnd   <= opB;
            cnt    <= 5'd0;
            is_div <= op_div;
        end else if (step) begin
            acc <= acc_next;
            wq  <= wq_next;
            if (last) begin
                hi <= acc_next;
                lo <= wq_next;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end
    end

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign alu_op    = busy ? step_op : ALU_ADD;
    assign alu_a     = busy ? step_a : 32'd0;
    assign alu_b     = busy ? step_b : 32'd0;
    assign alu_shamt = 5'd0;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, random
// operations against an arithmetic reference, and hand-written corner sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, op_div, flush;
    logic [31:0] opA, opB;
    logic [2:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] last_hi, last_lo;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        div;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    muldiv_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_div     (op_div),
        .opA        (opA),
        .opB        (opB),
        .flush      (flush),
        .alu_op     (alu_op),
        .alu_shamt  (alu_shamt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Stand-in for the EX-stage ALU, answering in the same cycle.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            3'b111:  alu_result = {31'd0, alu_a < alu_b};
            3'b011:  alu_result = alu_b >> alu_shamt;
            default: alu_result = 32'd0;
        endcase
    end

    function automatic logic [63:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic div);
        logic [63:0] r;
        if (!div)        r = {32'd0, a} * {32'd0, b};
        else if (b == 0) r = {a, 32'hFFFFFFFF};
        else             r = {a % b, a / b};
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at the negedge one cycle after the sampling edge (latency lat0);
    // returns at the negedge of the done cycle or after the cycle budget.
    task automatic waitDone(input int lat0, input logic div, output int lat, output int bc,
                            output logic got, output logic op_ok);
        lat   = lat0;
        bc    = 0;
        got   = 1'b0;
        op_ok = 1'b1;
        for (int i = 0; i < 45 && !got; i++) begin
            if (busy) begin
                bc++;
                if (alu_op !== (div ? 3'b110 : 3'b010) || alu_shamt !== 5'd0) op_ok = 1'b0;
            end
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic div,
                                 output int lat, output int bc, output logic got,
                                 output logic op_ok);
        @(negedge clk);
        start  = 1'b1;
        op_div = div;
        opA    = a;
        opB    = b;
        @(negedge clk);
        start = 1'b0;
        waitDone(1, div, lat, bc, got, op_ok);
    endtask

    task automatic runAndCheck(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic div, input logic [31:0] ehi, input logic [31:0] elo);
        int   lat, bc;
        logic got, op_ok;
        applyStimulus(a, b, div, lat, bc, got, op_ok);
        checkOutput({name, " done"}, {63'd0, got}, 64'd1);
        checkOutput({name, " latency"}, lat, 33);
        checkOutput({name, " busy_cycles"}, bc, 32);
        checkOutput({name, " alu_op"}, {63'd0, op_ok}, 64'd1);
        checkOutput({name, " hilo"}, {hi, lo}, {ehi, elo});
        last_hi = ehi;
        last_lo = elo;
    endtask

    initial begin
        int          lat, bc;
        logic        got, op_ok;
        logic [31:0] a, b;
        logic        div;
        logic [63:0] r;

        vecs[0] = '{32'd3,         32'd5,         1'b0, 32'h00000000, 32'h0000000F};
        vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'd100,       32'd7,         1'b1, 32'h00000002, 32'h0000000E};
        vecs[3] = '{32'h00001234,  32'd0,         1'b1, 32'h00001234, 32'hFFFFFFFF};
        vecs[4] = '{32'hDEADBEEF,  32'd1,         1'b1, 32'h00000000, 32'hDEADBEEF};
        vecs[5] = '{32'h12345678,  32'h10,        1'b0, 32'h00000001, 32'h23456780};
        vecs[6] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'h00000000, 32'h00000001};
        vecs[7] = '{32'd7,         32'd100,       1'b1, 32'h00000007, 32'h00000000};

        rst = 1'b1; start = 1'b0; op_div = 1'b0; flush = 1'b0; opA = '0; opB = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        checkOutput("reset hilo", {hi, lo}, 64'd0);
        checkOutput("reset alu_op", {61'd0, alu_op}, 64'd2);
        checkOutput("reset alu_ab", {alu_a, alu_b}, 64'd0);
        checkOutput("reset shamt", {59'd0, alu_shamt}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].div,
                        vecs[i].hi, vecs[i].lo);
        end

        for (int i = 0; i < 16; i++) begin
            a   = $urandom;
            div = $urandom_range(0, 1);
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (i == 5) b = 32'd0;
            r = refModel(a, b, div);
            runAndCheck($sformatf("rand%0d", i), a, b, div, r[63:32], r[31:0]);
        end

        @(negedge clk);
        checkOutput("idle alu_ab", {alu_a, alu_b}, 64'd0);

        // start while busy must be ignored
        a = 32'h0000BEEF; b = 32'h00000123;
        start = 1'b1; op_div = 1'b1; opA = a; opB = b;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op_div = 1'b0; opA = 32'hFFFF0000; opB = 32'h0000FFFF;
        @(negedge clk);
        start = 1'b0;
        waitDone(6, 1'b1, lat, bc, got, op_ok);
        r = refModel(a, b, 1'b1);
        checkOutput("ignore_start latency", lat, 33);
        checkOutput("ignore_start hilo", {hi, lo}, r);
        last_hi = r[63:32]; last_lo = r[31:0];

        // flush in RUN cycle 10
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; opA = 32'd9; opB = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush busy", {63'd0, busy}, 64'd0);
        checkOutput("flush done", {63'd0, done}, 64'd0);
        checkOutput("flush hilo", {hi, lo}, {last_hi, last_lo});
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) got = 1'b1;
        end
        checkOutput("flush quiet", {63'd0, got}, 64'd0);

        // flush coinciding with the final step
        start = 1'b1; op_div = 1'b0; opA = 32'd6; opB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        checkOutput("lastflush busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("lastflush done", {63'd0, done}, 64'd0);
        checkOutput("lastflush busy", {63'd0, busy}, 64'd0);
        checkOutput("lastflush hilo", {hi, lo}, {last_hi, last_lo});

        // start together with flush in IDLE: start wins
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op_div = 1'b0; opA = 32'd11; opB = 32'd13;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkOutput("idleflush busy", {63'd0, busy}, 64'd1);
        waitDone(1, 1'b0, lat, bc, got, op_ok);
        checkOutput("idleflush latency", lat, 33);
        checkOutput("idleflush hilo", {hi, lo}, 64'd143);

        // back-to-back: second start during the DONE cycle
        runAndCheck("b2b first", 32'd1000, 32'd33, 1'b1, 32'd10, 32'd30);
        checkOutput("b2b done_pulse", {63'd0, done}, 64'd1);
        start = 1'b1; op_div = 1'b0; opA = 32'h80000000; opB = 32'd4;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b busy", {63'd0, busy}, 64'd1);
        waitDone(1, 1'b0, lat, bc, got, op_ok);
        checkOutput("b2b second latency", lat, 33);
        checkOutput("b2b second hilo", {hi, lo}, 64'h0000000200000000);

        // reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; op_div = 1'b1; opA = 32'd77; opB = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst done", {63'd0, done}, 64'd0);
        checkOutput("midrst hilo", {hi, lo}, 64'd0);
        checkOutput("midrst alu_op", {61'd0, alu_op}, 64'd2);

        runAndCheck("after_rst", 32'd77, 32'd5, 1'b1, 32'd2, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
